// File: rtl/float16_accum_ctrl.sv
// Dot-product accumulation sequencer: feeds an external combinational float16
// adder with {acc, in_data} and folds LEN products into one sum.
module float16_accum_ctrl #(
    parameter int LEN   = 8,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_t            state, state_nx;
    logic [15:0]       acc, acc_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 16'h0000;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

    // abort outranks everything, including a beat in the same cycle
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_nx   = 16'h0000;
                        cnt_nx   = '0;
                        state_nx = ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_nx = add_result;
                        if (cnt == LAST) begin
                            cnt_nx   = '0;
                            state_nx = DONE;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // handshake outputs come from registered state only
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = out_valid ? acc : 16'h0000;
    assign add_a     = acc;
    assign add_b     = in_data;

endmodule

// File: tb/tb_float16_accum_ctrl.sv
// Bench for float16_accum_ctrl: three instances (LEN 4/2/1) each driving a
// behavioral float16 adder; finished sums are checked against a queue.
module tb_float16_accum_ctrl;
    logic              clk = 1'b0;
    logic              rst;
    logic              abort, in_valid, out_ready;
    logic [15:0]       in_data;
    logic [2:0]        st, ir, ov, bz;
    logic [2:0][15:0]  aa, ab, ar, od;

    int pass_cnt = 0;
    int total    = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    function automatic real pow2(int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(logic [15:0] h);
        int  e = int'(h[14:10]);
        real m = real'(h[9:0]);
        real r;
        if (e == 0) r = m * pow2(-24);
        else        r = (1024.0 + m) * pow2(e - 25);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(real r);
        logic s = (r < 0.0);
        real  a = s ? -r : r;
        int   e = 15;
        int   m;
        if (a == 0.0) return 16'h0000;
        while (a >= 2.0 && e < 30) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        if (a < 1.0) begin
            m = int'(a * 1024.0);
            e = 0;
        end else begin
            m = int'((a - 1.0) * 1024.0);
            if (m == 1024) begin m = 0; e++; end
        end
        return {s, 5'(e), 10'(m)};
    endfunction

    function automatic logic [15:0] f16_add(logic [15:0] a, logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    assign ar[0] = f16_add(aa[0], ab[0]);
    assign ar[1] = f16_add(aa[1], ab[1]);
    assign ar[2] = f16_add(aa[2], ab[2]);

    float16_accum_ctrl #(.LEN(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .start(st[0]), .abort(abort), .in_valid(in_valid),
        .in_ready(ir[0]), .in_data(in_data), .add_a(aa[0]), .add_b(ab[0]),
        .add_result(ar[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .busy(bz[0]));
    float16_accum_ctrl #(.LEN(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .start(st[1]), .abort(abort), .in_valid(in_valid),
        .in_ready(ir[1]), .in_data(in_data), .add_a(aa[1]), .add_b(ab[1]),
        .add_result(ar[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .busy(bz[1]));
    float16_accum_ctrl #(.LEN(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(st[2]), .abort(abort), .in_valid(in_valid),
        .in_ready(ir[2]), .in_data(in_data), .add_a(aa[2]), .add_b(ab[2]),
        .add_result(ar[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .busy(bz[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // handshake completes on the next rising edge; pop and compare here
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ov[i] && out_ready) begin
                if (q.size() == 0) chk("scoreboard_underflow", 32'(od[i]), 32'hFFFF_FFFF);
                else               chk("out_data", 32'(od[i]), 32'(q.pop_front()));
            end
        end
    end

    typedef struct {
        int          inst;
        int          n;
        logic [15:0] d [4];
        int          gap;
        logic [15:0] exp;
    } vec_t;

    function automatic vec_t mkv(int inst, int n, logic [15:0] d0, logic [15:0] d1,
                                 logic [15:0] d2, logic [15:0] d3, int gap, logic [15:0] exp);
        vec_t v;
        v.inst = inst; v.n = n; v.gap = gap; v.exp = exp;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    task automatic run_vector(input vec_t v, input bit release_out);
        logic [15:0] part = 16'h0000;
        q.push_back(v.exp);
        st[v.inst] = 1'b1;
        step();
        st[v.inst] = 1'b0;
        chk("start_in_ready", 32'(ir[v.inst]), 32'd1);
        chk("start_busy", 32'(bz[v.inst]), 32'd1);
        for (int k = 0; k < v.n; k++) begin
            if (k > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    step();
                    chk("gap_acc_hold", 32'(aa[v.inst]), 32'(part));
                end
            end
            if (k == v.n - 1) chk("pre_last_out_valid", 32'(ov[v.inst]), 32'd0);
            in_valid = 1'b1;
            in_data  = v.d[k];
            part     = f16_add(part, v.d[k]);
            step();
            in_valid = 1'b0;
        end
        chk("done_out_valid", 32'(ov[v.inst]), 32'd1);
        chk("done_in_ready", 32'(ir[v.inst]), 32'd0);
        if (release_out) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("idle_out_valid", 32'(ov[v.inst]), 32'd0);
            chk("idle_busy", 32'(bz[v.inst]), 32'd0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mkv(0, 4, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0, 16'h4400);
        vecs[1] = mkv(1, 2, 16'h4300, 16'h4100, 16'h0000, 16'h0000, 3, 16'h4600);
        vecs[2] = mkv(1, 2, 16'hC300, 16'h4100, 16'h0000, 16'h0000, 0, 16'hBC00);
        vecs[3] = mkv(2, 1, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 0, 16'hBC00);
        vecs[4] = mkv(0, 4, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 1, 16'h4900);

        rst = 1'b1; st = '0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 16'h1234;
        #12;
        chk("rst_in_ready", 32'(ir[0]), 32'd0);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_out_data", 32'(od[0]), 32'h0);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_add_a", 32'(aa[0]), 32'h0);
        chk("rst_add_b", 32'(ab[0]), 32'h1234);
        step();
        rst = 1'b0;
        step();

        // partial sum of 2.0, then asynchronous reset mid-ACCUM
        st[0] = 1'b1; step(); st[0] = 1'b0;
        in_valid = 1'b1; in_data = 16'h3C00;
        step(); step();
        in_valid = 1'b0;
        chk("partial_acc", 32'(aa[0]), 32'h4000);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bz[0]), 32'd0);
        chk("async_rst_in_ready", 32'(ir[0]), 32'd0);
        chk("async_rst_acc", 32'(aa[0]), 32'h0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_vector(vecs[i], 1'b1);

        // DONE held: start and in_valid pulses must be ignored
        run_vector(mkv(1, 2, 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 0, 16'h4000), 1'b0);
        for (int c = 0; c < 5; c++) begin
            st[1] = c[0]; in_valid = ~c[0]; in_data = 16'h3C00;
            step();
            chk("hold_out_valid", 32'(ov[1]), 32'd1);
            chk("hold_out_data", 32'(od[1]), 32'h4000);
            chk("hold_in_ready", 32'(ir[1]), 32'd0);
        end
        st[1] = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_out_valid", 32'(ov[1]), 32'd0);
        step();
        chk("start_not_queued", 32'(bz[1]), 32'd0);

        // abort together with the 3rd beat
        st[0] = 1'b1; step(); st[0] = 1'b0;
        in_valid = 1'b1; in_data = 16'h3C00;
        step(); step();
        abort = 1'b1; in_data = 16'h4000;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(bz[0]), 32'd0);
        chk("abort_in_ready", 32'(ir[0]), 32'd0);
        chk("abort_acc_kept", 32'(aa[0]), 32'h4000);
        run_vector(mkv(0, 4, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00, 0, 16'h4500), 1'b1);

        // start and abort together in IDLE: abort wins
        st[0] = 1'b1; abort = 1'b1;
        step();
        st[0] = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(bz[0]), 32'd0);

        step();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
